// File: rtl/avst_to_axis_if.sv
// avst_to_axis_if: Avalon-ST receive side and AXI4-Stream transmit side of the converter.
// The master view belongs to the environment and the slave view to the converter.
interface avst_to_axis_if #(
  parameter int DWIDTH = 512,
  parameter int USER_WIDTH = 1,
  parameter int ERR_WIDTH = 1
);
  localparam int EMPTY_MSB = $clog2(DWIDTH / 8);
  logic avst_valid, avst_start, avst_end, avst_ready;
  logic [DWIDTH-1:0] avst_data;
  logic [EMPTY_MSB-1:0] avst_empty;
  logic [ERR_WIDTH-1:0] avst_error;
  logic axis_tvalid, axis_tlast, axis_tready;
  logic [DWIDTH-1:0] axis_tdata;
  logic [DWIDTH/8-1:0] axis_tkeep;
  logic [USER_WIDTH-1:0] axis_tuser;
  modport master (
    output avst_valid, avst_start, avst_end, avst_data, avst_empty, avst_error, axis_tready,
    input avst_ready, axis_tvalid, axis_tdata, axis_tlast, axis_tkeep, axis_tuser
  );
  modport slave (
    input avst_valid, avst_start, avst_end, avst_data, avst_empty, avst_error, axis_tready,
    output avst_ready, axis_tvalid, axis_tdata, axis_tlast, axis_tkeep, axis_tuser
  );
endinterface

// File: rtl/avst_to_axis.sv
// avst_to_axis: Avalon-ST to AXI4-Stream converter with SOP/EOP framing enforcement
// and an elastic buffer sized to absorb the source ready latency.
module avst_to_axis #(
  parameter int DWIDTH = 512,
  parameter int USER_WIDTH = 1,
  parameter int ERR_WIDTH = 1,
  parameter int READY_LATENCY = 0
) (
  input  logic clk,
  input  logic rst_n,
  avst_to_axis_if.slave bus,
  output logic err_sop_missing,
  output logic err_eop_missing,
  output logic [15:0] drop_cnt
);
  localparam int KEEP_WIDTH = DWIDTH / 8;
  localparam int DEPTH = READY_LATENCY + 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;
  state_t state;
  logic [DWIDTH-1:0] mem_data [DEPTH];
  logic [KEEP_WIDTH-1:0] mem_keep [DEPTH];
  logic [USER_WIDTH-1:0] mem_user [DEPTH];
  logic [DEPTH-1:0] mem_last;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic acc, rd, wr, term, drop, in_pkt;
  logic [DWIDTH-1:0] cv_data;
  logic [KEEP_WIDTH-1:0] cv_keep;
  // Ready leaves room for every beat that can still arrive from earlier ready cycles.
  assign bus.avst_ready = count <= CW'(DEPTH - READY_LATENCY - 1);
  if (READY_LATENCY == 0) begin : g_rl0
    assign acc = bus.avst_valid && bus.avst_ready;
  end else begin : g_rl
    logic [READY_LATENCY-1:0] hist;
    logic [READY_LATENCY:0] sh;
    assign sh = {hist, bus.avst_ready};
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) hist <= '0;
      else hist <= sh[READY_LATENCY-1:0];
    assign acc = bus.avst_valid && sh[READY_LATENCY];
  end
  for (genvar j = 0; j < KEEP_WIDTH; j++) begin : g_swap
    assign cv_data[8*j +: 8] = bus.avst_data[8*(KEEP_WIDTH-1-j) +: 8];
  end
  assign cv_keep = bus.avst_end ? {KEEP_WIDTH{1'b1}} >> bus.avst_empty : '1;
  assign in_pkt = state == IN_PKT;
  assign term = bus.avst_start && in_pkt;
  assign wr = acc && (bus.avst_start || in_pkt);
  // Discarded beats: stray body beats outside a packet, and the SOP that truncates one.
  assign drop = acc && (bus.avst_start == in_pkt);
  assign rd = bus.axis_tvalid && bus.axis_tready;
  assign bus.axis_tvalid = count != '0;
  assign bus.axis_tdata = mem_data[rp];
  assign bus.axis_tkeep = mem_keep[rp];
  assign bus.axis_tuser = mem_user[rp];
  assign bus.axis_tlast = mem_last[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      err_sop_missing <= 1'b0;
      err_eop_missing <= 1'b0;
      drop_cnt <= '0;
      mem_last <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_keep[i] <= '0;
        mem_user[i] <= '0;
      end
    end else begin
      err_sop_missing <= acc && !bus.avst_start && state == IDLE;
      err_eop_missing <= acc && term;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (acc)
        state <= bus.avst_start ? (bus.avst_end ? IDLE : (in_pkt ? DROP : IN_PKT))
                                : ((state == IDLE || bus.avst_end) ? IDLE : state);
      if (wr) begin
        mem_data[wp] <= term ? '0 : cv_data;
        mem_keep[wp] <= term ? '0 : cv_keep;
        mem_user[wp] <= USER_WIDTH'(term || |bus.avst_error);
        mem_last[wp] <= term || bus.avst_end;
        wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
      end
      if (rd) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: doc/avst_to_axis.md
# avst_to_axis

Converts an Avalon-ST packet stream from a MAC/PCS-side source back into the AXI4-Stream format used by the sensor-bridge datapath. It is the receive-direction counterpart to the existing AXIS-to-AVST conversion. The block supports a source ready latency of 0–3 through an internal elastic buffer and restores AXIS byte order (first byte in lane 0). It enforces SOP/EOP framing, dropping or terminating malformed packets and reporting each event.

## Interface
Parameters:
- DWIDTH, 512, data width in bits; multiple of 8.
- USER_WIDTH, 1, axis_tuser width.
- ERR_WIDTH, 1, avst_error width.
- READY_LATENCY, 0, Avalon-ST readyLatency; legal values 0..3.
- Derived, not overridable: KEEP_WIDTH = DWIDTH/8; EMPTY_MSB = $clog2(KEEP_WIDTH); DEPTH = READY_LATENCY+2 (buffer entries).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- avst_valid  in  1  source beat valid.
- avst_start  in  1  start of packet.
- avst_end  in  1  end of packet.
- avst_data  in  DWIDTH  payload; first symbol in the MSB byte.
- avst_empty  in  EMPTY_MSB  unused bytes on the end beat.
- avst_error  in  ERR_WIDTH  packet error.
- avst_ready  out  1  sink ready.
- axis_tvalid  out  1  output beat valid.
- axis_tdata  out  DWIDTH  byte-swapped payload.
- axis_tlast  out  1  end of packet.
- axis_tkeep  out  KEEP_WIDTH  byte enables.
- axis_tuser  out  USER_WIDTH  error flag in bit 0; other bits 0.
- axis_tready  in  1  downstream ready.
- err_sop_missing  out  1  one-cycle pulse when a beat is dropped outside a packet.
- err_eop_missing  out  1  one-cycle pulse when a packet is truncated by a new SOP.
- drop_cnt  out  16  saturating count of discarded beats.

## Operation
- Accept rule:
  - READY_LATENCY=0: a beat is accepted when avst_valid && avst_ready.
  - READY_LATENCY=L>0: a beat is accepted when avst_valid is high and avst_ready was high L cycles earlier. The ready history uses an L-deep shift register, reset to 0.
- avst_ready = (occupancy <= DEPTH-READY_LATENCY-1), combinational from the buffer count. This guarantees no overflow while up to L beats are in flight.
- Beat conversion, applied before the buffer write:
  - tdata byte j = avst_data byte (KEEP_WIDTH-1-j).
  - tlast = avst_end.
  - tkeep = all ones when avst_end=0; otherwise the low (KEEP_WIDTH - avst_empty) bits are set and the rest are 0.
  - tuser[0] = |avst_error.
- Framing FSM, advanced only on accepted beats:
  - IDLE, start=1: the beat is written. Next state is IDLE if end=1, else IN_PKT.
  - IDLE, start=0: the beat is discarded; err_sop_missing pulses; drop_cnt increments. State stays IDLE.
  - IN_PKT, start=0: the beat is written. end=1 → IDLE.
  - IN_PKT, start=1: write a terminator beat in place of the incoming beat, with tlast=1, tkeep=0, tuser[0]=1, tdata=0. err_eop_missing pulses and drop_cnt increments. Next state is DROP, or IDLE if end=1.
  - DROP, start=0: the beat is discarded and drop_cnt increments. end=1 → IDLE.
  - DROP, start=1: handled exactly as IDLE with start=1 (resync); no error pulse.
- drop_cnt saturates at 16'hFFFF.
- Buffer: DEPTH-entry circular FIFO. A write and a read in the same cycle leave occupancy unchanged and are legal even when the FIFO is full.
- axis_tvalid = (occupancy != 0). The head entry drives the payload outputs and is popped on axis_tvalid && axis_tready.
- Reset (asserted at any time, including mid-packet):
  - Immediately: FIFO empty, storage zeroed, FSM=IDLE, drop_cnt=0, ready history cleared.
  - Outputs: axis_tvalid=0, tdata/tkeep/tuser/tlast=0, err pulses=0.
  - avst_ready=1 (occupancy 0) once rst_n deasserts. Any partial packet is lost without an error pulse.

## Timing
- Latency: a beat accepted at cycle t is visible on axis_* at t+1 when the FIFO was empty.
- Throughput: 1 beat/cycle sustained while axis_tready=1, for every legal READY_LATENCY.
- AXIS rule: once axis_tvalid=1, the head payload is held stable until the beat is taken.
- err_sop_missing and err_eop_missing are registered; each pulses at t+1 for the triggering beat at t.
- drop_cnt updates at t+1.

## Test plan
- L=0, DWIDTH=64: 3-beat packet, end beat with empty=3, axis_tready=1 → 3 output beats at t+1, tkeep of the last beat = 8'h1F, data byte-reversed, tlast only on beat 3.
- L=2: assert axis_tready=0 with a continuous source → avst_ready drops when occupancy >1. No beat is lost or duplicated over 20 beats; the FIFO never exceeds 4 entries.
- Beat with start=0 after reset → no output, err_sop_missing=1 for one cycle, drop_cnt=1.
- SOP, 1 body beat, then SOP+2 beats+EOP → third output is a terminator (tlast=1, tkeep=0, tuser[0]=1). err_eop_missing pulses; the 2 following beats are dropped; drop_cnt=3.
- Single-beat packet (start=end=1, avst_error=1, empty=0) → one beat out with tlast=1, tkeep all ones, tuser=1.
- Assert rst_n low mid-packet with 2 beats buffered → axis_tvalid=0 immediately. After release, a fresh SOP packet passes cleanly with no error pulse.
